// File: rtl/cereal_rx.sv
// 8N1 serial receiver (idle-high, LSB first): one byte and a one-cycle valid per good frame, frame_err on a low stop bit.
// Define CEREAL_RX_SYNC_EN to put a two-flop synchronizer on rx (adds 2 cycles of latency).
module cereal_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             tick_half;
    logic             tick_bit;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             idx_clr;
    logic             shift_en;
    logic             load_byte;
    logic             flag_err;

`ifdef CEREAL_RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    assign tick_half = (cnt == HALF_LAST);
    assign tick_bit  = (cnt == BIT_LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (tick_half) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick_bit && idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (tick_bit) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        flag_err  = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: cnt_clr = !rx_s;
            S_START: begin
                if (tick_half) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (tick_bit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_STOP: begin
                if (tick_bit) begin
                    cnt_clr   = 1'b1;
                    load_byte = rx_s;
                    flag_err  = !rx_s;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bit-timing counter and byte assembly; the index wraps from 7 to 0 on its own.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (shift_en) begin
            shreg[idx] <= rx_s;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= load_byte;
            frame_err <= flag_err;
            if (load_byte) begin
                data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_cereal_rx.sv
// Scoreboard bench for cereal_rx at CLKS_PER_BIT=16: directed frames plus random good/bad frames.
module tb_cereal_rx;

    localparam int CPB = 16;
`ifdef CEREAL_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit          is_err;
        logic [7:0]  dat;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  model_last = 8'h00;

    cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic void check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    // A frame starting now has its stop sample at t0+152, t0 being the next edge (plus sync latency).
    task automatic send_frame(input logic [7:0] b, input bit good, input int low_hold);
        exp_t e;
        e.is_err = !good;
        e.cyc    = cyc + 153 + LAT;
        if (good) model_last = b;
        e.dat = model_last;
        q.push_back(e);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = good;
        hold(CPB);
        if (!good) begin
            rx = 1'b0;
            hold(low_hold);
            rx = 1'b1;
        end
    endtask

    always @(negedge sysclk) begin
        if (rst_n === 1'b1 && (valid || frame_err)) begin
            check("strobe_exclusive", valid && frame_err, 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe actual=valid%0b/err%0b required=none (cycle %0d)",
                         valid, frame_err, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind_err", frame_err, e.is_err);
                check("strobe_data", data, e.dat);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int unsigned n;
        logic [7:0]  d;
        logic [7:0]  b;
        bit          good;

        rx    = 1'b1;
        rst_n = 1'b0;
        hold(3);
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        hold(5);

        // Good byte with busy window
        n = cyc;
        fork
            send_frame(8'h45, 1'b1, 0);
            begin
                hold(LAT);
                check("busy_before_t0", busy, 0);
                hold(1);
                check("busy_at_t0p1", busy, 1);
                hold(151);
                check("busy_at_t0p152", busy, 1);
                hold(1);
                check("busy_after_stop", busy, 0);
            end
        join
        hold(10);

        // Back-to-back "ENG"
        send_frame(8'h45, 1'b1, 0);
        send_frame(8'h4E, 1'b1, 0);
        send_frame(8'h47, 1'b1, 0);
        hold(10);

        // Glitch: 4 low cycles
        d  = model_last;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(4 + LAT);
        check("glitch_busy_before_resample", busy, 1);
        hold(1);
        check("glitch_busy_after_resample", busy, 0);
        check("glitch_data_kept", data, d);
        hold(10);

        // Framing error, then recovery
        send_frame(8'h20, 1'b0, 40);
        hold(16);
        check("break_exit_busy", busy, 0);
        send_frame(8'h41, 1'b1, 0);
        hold(5);

        // Reset during data bit 3 of 0x54
        b  = 8'h54;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = b[3];
        hold(5);
        rst_n = 1'b0;
        #1;
        check("midreset_data", data, 0);
        check("midreset_valid", valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_busy", busy, 0);
        check("midreset_queue_empty", q.size(), 0);
        model_last = 8'h00;
        rx = 1'b1;
        hold(3);
        rst_n = 1'b1;
        hold(5);
        send_frame(8'h55, 1'b1, 0);
        hold(5);

        // Random mix of good and malformed frames with random gaps
        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, int'($urandom_range(0, 30)));
            if (good) hold(int'($urandom_range(0, 12)));
            else      hold(int'($urandom_range(2, 12)));
        end

        hold(200);
        check("final_queue_empty", q.size(), 0);
        check("final_data", data, model_last);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
